// File: rtl/line_fill_arbiter.sv
// ============================================================================
// line_fill_arbiter
// ----------------------------------------------------------------------------
// Shares one AXI4 read channel between NUM_REQ instruction-cache controllers.
// One pending requester is picked, a single INCR burst covering the whole
// cache line is issued, and the returning beats are steered back to the
// granted requester only.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration. The priority pointer starts at 0
//                and moves to (winner+1) mod NUM_REQ when a burst completes.
//   undefined -> fixed priority. The lowest-index active request wins and no
//                pointer is built.
//
// Ports
//   i_aclk, i_areset      clock, asynchronous active-high reset
//   i_req[NUM_REQ]        per-requester refill request (level)
//   i_addr[NUM_REQ]       per-requester miss address
//   o_gnt[NUM_REQ]        one-hot grant, held for the whole transaction
//   o_rdata               beat data, shared by all requesters
//   o_rvalid[NUM_REQ]     per-requester beat strobe
//   o_rlast, o_rerr       last beat / non-OKAY beat, qualified by o_rvalid
//   o_ar*, i_arready      AXI read-address channel (INCR, BURST_LEN beats)
//   i_r*, o_rready        AXI read-data channel
//   o_proto_err           sticky burst-length mismatch flag, cleared by reset
// ============================================================================
module line_fill_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                                i_aclk,
    input  logic                                i_areset,
    input  logic [NUM_REQ-1:0]                  i_req,
    input  logic [NUM_REQ-1:0][ADDR_SIZE-1:0]   i_addr,
    output logic [NUM_REQ-1:0]                  o_gnt,
    output logic [DATA_WIDTH-1:0]               o_rdata,
    output logic [NUM_REQ-1:0]                  o_rvalid,
    output logic                                o_rlast,
    output logic                                o_rerr,
    output logic [ADDR_SIZE-1:0]                o_araddr,
    output logic [7:0]                          o_arlen,
    output logic [2:0]                          o_arsize,
    output logic [1:0]                          o_arburst,
    output logic                                o_arvalid,
    input  logic                                i_arready,
    input  logic [DATA_WIDTH-1:0]               i_rdata,
    input  logic [1:0]                          i_rresp,
    input  logic                                i_rvalid,
    input  logic                                i_rlast,
    output logic                                o_rready,
    output logic                                o_proto_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam int OFF_W = $clog2(BURST_LEN * DATA_WIDTH / 8);

    // Clears the byte offset within a line.
    localparam logic [ADDR_SIZE-1:0] LINE_MASK = {ADDR_SIZE{1'b1}} << OFF_W;
    localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]     MAX_CNT   = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [NUM_REQ-1:0]     gnt_reg;
    logic [ADDR_SIZE-1:0]   araddr_reg;
    logic [CNT_W-1:0]       beat_cnt_reg;
    logic                   proto_err_reg;

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [ADDR_SIZE-1:0]   line_addr [NUM_REQ];

    logic                   beat_acc;
    logic                   burst_done;
    logic                   len_mismatch;
    logic                   rvalid_en;

    // ------------------------------------------------------------------------
    // Constant AXI burst attributes
    // ------------------------------------------------------------------------
    assign o_arlen   = 8'(BURST_LEN - 1);
    assign o_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign o_arburst = 2'b01;

    // ------------------------------------------------------------------------
    // Per-requester line-aligned addresses
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_line_addr
            assign line_addr[gi] = i_addr[gi] & LINE_MASK;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]       ptr_reg;
    logic [IDX_W-1:0]       gnt_idx_reg;

    // Rotating search: the first active request at or after the pointer wins.
    always_comb begin
        logic [IDX_W-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr_reg) + k) % NUM_REQ);
            if (!win_found && i_req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // The winner's index is remembered so the pointer can skip past it once
    // its burst has fully returned.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            ptr_reg     <= '0;
            gnt_idx_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && win_found) begin
                gnt_idx_reg <= win_idx;
            end
            if (burst_done) begin
                ptr_reg <= (gnt_idx_reg == IDX_W'(NUM_REQ - 1)) ?
                           '0 : gnt_idx_reg + 1'b1;
            end
        end
    end
`else
    // Fixed priority: scanning downward leaves the lowest active index last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Beat acceptance and burst-length check
    // ------------------------------------------------------------------------
    assign beat_acc   = (state_reg == ST_DATA) && i_rvalid;
    assign burst_done = beat_acc && i_rlast;

    // Either the burst ended early/late, or the final expected beat was not
    // marked last. Completion itself always follows i_rlast.
    assign len_mismatch = ( i_rlast && (beat_cnt_reg != LAST_CNT)) ||
                          (!i_rlast && (beat_cnt_reg == LAST_CNT));

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (win_found)  state_next = ST_ADDR;
            ST_ADDR: if (i_arready)  state_next = ST_DATA;
            ST_DATA: if (burst_done) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // Beat fields are forwarded combinationally so data reaches the cache in
    // the same cycle it arrives; outside DATA everything is held at zero.
    // ------------------------------------------------------------------------
    always_comb begin
        o_arvalid = 1'b0;
        o_rready  = 1'b0;
        o_rdata   = '0;
        o_rlast   = 1'b0;
        o_rerr    = 1'b0;
        rvalid_en = 1'b0;
        case (state_reg)
            ST_ADDR: begin
                o_arvalid = 1'b1;
            end
            ST_DATA: begin
                o_rready  = 1'b1;
                o_rdata   = i_rdata;
                rvalid_en = i_rvalid;
                o_rlast   = i_rvalid && i_rlast;
                o_rerr    = i_rvalid && (i_rresp != 2'b00);
            end
            default: begin
            end
        endcase
    end

    // Only the granted requester ever sees a beat strobe.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rvalid
            assign o_rvalid[gi] = rvalid_en & gnt_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Grant, address, beat counter and sticky protocol error
    // ------------------------------------------------------------------------
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            gnt_reg       <= '0;
            araddr_reg    <= '0;
            beat_cnt_reg  <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win_found) begin
                        gnt_reg    <= NUM_REQ'(1) << win_idx;
                        araddr_reg <= line_addr[win_idx];
                    end
                end
                ST_ADDR: begin
                    if (i_arready) begin
                        beat_cnt_reg <= '0;
                    end
                end
                ST_DATA: begin
                    if (beat_acc) begin
                        // Saturate so an overlong burst cannot wrap back to
                        // a count that looks legal.
                        if (beat_cnt_reg != MAX_CNT) begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                        if (len_mismatch) begin
                            proto_err_reg <= 1'b1;
                        end
                        if (i_rlast) begin
                            gnt_reg <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_gnt       = gnt_reg;
    assign o_araddr    = araddr_reg;
    assign o_proto_err = proto_err_reg;

endmodule

// File: tb/tb_line_fill_arbiter.sv
// ============================================================================
// tb_line_fill_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for line_fill_arbiter (NUM_REQ=4, 32-bit address/data,
// BURST_LEN=4). A table of single-requester transactions is applied in a
// loop; the returning beats are checked through a scoreboard queue. Hand
// sequences cover reset mid-burst and multi-requester arbitration order.
// Expectations follow ARB_ROUND_ROBIN_EN where the two builds differ.
// ============================================================================
module tb_line_fill_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ADDR_SIZE  = 32;
    localparam int DATA_WIDTH = 32;
    localparam int BURST_LEN  = 4;

    logic                              i_aclk;
    logic                              i_areset;
    logic [NUM_REQ-1:0]                i_req;
    logic [NUM_REQ-1:0][ADDR_SIZE-1:0] i_addr;
    logic [NUM_REQ-1:0]                o_gnt;
    logic [DATA_WIDTH-1:0]             o_rdata;
    logic [NUM_REQ-1:0]                o_rvalid;
    logic                              o_rlast;
    logic                              o_rerr;
    logic [ADDR_SIZE-1:0]              o_araddr;
    logic [7:0]                        o_arlen;
    logic [2:0]                        o_arsize;
    logic [1:0]                        o_arburst;
    logic                              o_arvalid;
    logic                              i_arready;
    logic [DATA_WIDTH-1:0]             i_rdata;
    logic [1:0]                        i_rresp;
    logic                              i_rvalid;
    logic                              i_rlast;
    logic                              o_rready;
    logic                              o_proto_err;

    line_fill_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_SIZE  (ADDR_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) dut (
        .i_aclk      (i_aclk),
        .i_areset    (i_areset),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .o_gnt       (o_gnt),
        .o_rdata     (o_rdata),
        .o_rvalid    (o_rvalid),
        .o_rlast     (o_rlast),
        .o_rerr      (o_rerr),
        .o_araddr    (o_araddr),
        .o_arlen     (o_arlen),
        .o_arsize    (o_arsize),
        .o_arburst   (o_arburst),
        .o_arvalid   (o_arvalid),
        .i_arready   (i_arready),
        .i_rdata     (i_rdata),
        .i_rresp     (i_rresp),
        .i_rvalid    (i_rvalid),
        .i_rlast     (i_rlast),
        .o_rready    (o_rready),
        .o_proto_err (o_proto_err)
    );

    initial i_aclk = 1'b0;
    always #5 i_aclk = ~i_aclk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NUM_REQ-1:0]    rvalid;
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic                  err;
    } beat_t;

    beat_t sb[$];

    typedef struct {
        int          req;
        logic [31:0] addr;
        logic [31:0] exp_araddr;
        int          stall;
        int          last_beat;
        int          err_beat;
        logic        exp_proto;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge i_aclk);
        i_areset = 1'b1;
        @(negedge i_aclk);
        i_areset = 1'b0;
    endtask

    // Starts one negedge before the ADDR state is expected; returns on the
    // negedge of the IDLE cycle that follows the rlast beat.
    task automatic do_burst(input int idx, input logic [31:0] exp_araddr,
                            input int stall, input int last_beat,
                            input int err_beat, input bit drop,
                            input logic [31:0] dbase);
        beat_t e;
        beat_t got;
        @(negedge i_aclk);
        check("gnt", o_gnt, 64'(1) << idx);
        check("arvalid", o_arvalid, 1);
        check("araddr", o_araddr, exp_araddr);
        check("rready_in_addr", o_rready, 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge i_aclk);
            check("stall_gnt", o_gnt, 64'(1) << idx);
            check("stall_arvalid", o_arvalid, 1);
            check("stall_araddr", o_araddr, exp_araddr);
        end
        i_arready = 1'b1;
        @(negedge i_aclk);
        i_arready = 1'b0;
        check("rready", o_rready, 1);
        check("arvalid_in_data", o_arvalid, 0);
        for (int b = 0; b <= last_beat; b++) begin
            i_rvalid = 1'b1;
            i_rdata  = dbase + 32'(b);
            i_rlast  = (b == last_beat);
            i_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            e.rvalid = NUM_REQ'(1) << idx;
            e.data   = dbase + 32'(b);
            e.last   = (b == last_beat);
            e.err    = (b == err_beat);
            sb.push_back(e);
            #1;
            got.rvalid = o_rvalid;
            got.data   = o_rdata;
            got.last   = o_rlast;
            got.err    = o_rerr;
            e = sb.pop_front();
            check("beat_rvalid", got.rvalid, e.rvalid);
            check("beat_rdata", got.data, e.data);
            check("beat_rlast", got.last, e.last);
            check("beat_rerr", got.err, e.err);
            @(negedge i_aclk);
        end
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        i_rresp  = 2'b00;
        if (drop) i_req[idx] = 1'b0;
        #1;
        check("gnt_cleared", o_gnt, 0);
        check("rready_idle", o_rready, 0);
        $display("burst req=%0d araddr=%08h beats=%0d proto_err=%0b",
                 idx, exp_araddr, last_beat + 1, o_proto_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          order_idx;
        logic [31:0] a;
        beat_t       e;

        vecs[0] = '{1, 32'h0000_1234, 32'h0000_1230, 0, 3, -1, 1'b0};
        vecs[1] = '{2, 32'h8000_007C, 32'h8000_0070, 5, 3, -1, 1'b0};
        vecs[2] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 0, 3,  1, 1'b0};
        vecs[3] = '{0, 32'h0000_000F, 32'h0000_0000, 1, 3, -1, 1'b0};
        vecs[4] = '{1, 32'h0000_2008, 32'h0000_2000, 0, 2, -1, 1'b1};
        vecs[5] = '{2, 32'h0000_3010, 32'h0000_3010, 0, 3, -1, 1'b1};
        vecs[6] = '{0, 32'h0000_4000, 32'h0000_4000, 2, 3,  2, 1'b1};

        i_areset  = 1'b1;
        i_req     = '0;
        i_addr    = '0;
        i_arready = 1'b0;
        i_rdata   = '0;
        i_rresp   = 2'b00;
        i_rvalid  = 1'b0;
        i_rlast   = 1'b0;

        // Reset state
        repeat (2) @(negedge i_aclk);
        check("rst_gnt", o_gnt, 0);
        check("rst_arvalid", o_arvalid, 0);
        check("rst_rready", o_rready, 0);
        check("rst_rvalid", o_rvalid, 0);
        check("rst_araddr", o_araddr, 0);
        check("rst_proto_err", o_proto_err, 0);
        check("arlen", o_arlen, 3);
        check("arsize", o_arsize, 2);
        check("arburst", o_arburst, 1);
        i_areset = 1'b0;

        // Beats offered in IDLE are not accepted
        @(negedge i_aclk);
        i_rvalid = 1'b1;
        i_rlast  = 1'b1;
        #1;
        check("idle_rready", o_rready, 0);
        check("idle_rvalid", o_rvalid, 0);
        check("idle_rlast", o_rlast, 0);
        @(negedge i_aclk);
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        check("idle_no_gnt", o_gnt, 0);

        // Table-driven single-requester transactions
        for (int v = 0; v < 7; v++) begin
            @(negedge i_aclk);
            i_req[vecs[v].req]  = 1'b1;
            i_addr[vecs[v].req] = vecs[v].addr;
            do_burst(vecs[v].req, vecs[v].exp_araddr, vecs[v].stall,
                     vecs[v].last_beat, vecs[v].err_beat, 1'b1,
                     32'hA0 + (32'(v) << 8));
            check("proto_err", o_proto_err, vecs[v].exp_proto);
        end

        // Reset asserted during DATA beat 2
        @(negedge i_aclk);
        i_req[2]  = 1'b1;
        i_addr[2] = 32'h0000_0040;
        @(negedge i_aclk);
        check("mid_gnt", o_gnt, 4'b0100);
        i_arready = 1'b1;
        @(negedge i_aclk);
        i_arready = 1'b0;
        i_rvalid  = 1'b1;
        i_rdata   = 32'h0000_00B0;
        e.rvalid  = 4'b0100;
        e.data    = 32'h0000_00B0;
        e.last    = 1'b0;
        e.err     = 1'b0;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check("mid_beat0_rvalid", o_rvalid, e.rvalid);
        check("mid_beat0_rdata", o_rdata, e.data);
        @(negedge i_aclk);
        i_rdata  = 32'h0000_00B1;
        i_areset = 1'b1;
        #1;
        check("mid_rst_gnt", o_gnt, 0);
        check("mid_rst_arvalid", o_arvalid, 0);
        check("mid_rst_rready", o_rready, 0);
        check("mid_rst_rvalid", o_rvalid, 0);
        check("mid_rst_rlast", o_rlast, 0);
        check("mid_rst_rerr", o_rerr, 0);
        check("mid_rst_araddr", o_araddr, 0);
        check("mid_rst_proto_err", o_proto_err, 0);
        $display("reset during beat 2: gnt=%0b proto_err=%0b", o_gnt, o_proto_err);
        @(negedge i_aclk);
        i_areset = 1'b0;
        i_rvalid = 1'b0;
        i_req    = '0;
        @(negedge i_aclk);
        i_req[1]  = 1'b1;
        i_addr[1] = 32'h0000_1234;
        do_burst(1, 32'h0000_1230, 0, 3, -1, 1'b1, 32'hA0);
        check("post_rst_proto_err", o_proto_err, 0);

        // All four request together, each drops after its burst
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) begin
            a = 32'h100 * k + 32'h14 + k;
            i_addr[k] = a;
        end
        i_req = '1;
        for (int n = 0; n < NUM_REQ; n++) begin
            do_burst(n, 32'h100 * n + 32'h10, 0, 3, -1, 1'b1, 32'hC0 + 32'(n << 4));
        end
        check("arb_a_all_served", o_gnt, 0);

        // All four request, requester 0 re-requests after every burst
        do_reset();
        i_req = '1;
        for (int n = 0; n < NUM_REQ; n++) begin
`ifdef ARB_ROUND_ROBIN_EN
            order_idx = n;
`else
            order_idx = 0;
`endif
            do_burst(order_idx, 32'h100 * order_idx + 32'h10, 0, 3, -1,
                     order_idx != 0, 32'hD0 + 32'(n << 4));
        end
        i_req = '0;
        repeat (2) @(negedge i_aclk);
        check("end_idle_gnt", o_gnt, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_fill_arbiter.md
# line_fill_arbiter

Shares one AXI4 read channel between NUM_REQ instruction-cache controllers (one per core) that need line refills on a miss. Picks one pending requester, issues a single INCR burst read for the whole cache line, and steers the returning beats back to the granted requester only. Sits between the per-core cache controllers and the memory-side AXI interconnect.

## Interface
- NUM_REQ, 4: number of requesting cache controllers (2..8).
- ADDR_SIZE, 32: address width.
- DATA_WIDTH, 32: AXI data width, equal to INST_SIZE.
- BURST_LEN, 4: beats per line, equal to WORDS_PER_LINE (power of two, 1..16).

Ports:
- i_aclk  in  1  system clock.
- i_areset  in  1  asynchronous, active-high reset.
- i_req  in  NUM_REQ  per-requester refill request (level).
- i_addr  in  NUM_REQ x ADDR_SIZE  per-requester miss address.
- o_gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- o_rdata  out  DATA_WIDTH  beat data, shared by all requesters.
- o_rvalid  out  NUM_REQ  per-requester beat strobe.
- o_rlast  out  1  last beat of the line, qualified by o_rvalid.
- o_rerr  out  1  beat carried a non-OKAY response, qualified by o_rvalid.
- o_araddr  out  ADDR_SIZE  AXI read address.
- o_arlen  out  8  constant BURST_LEN-1.
- o_arsize  out  3  constant $clog2(DATA_WIDTH/8).
- o_arburst  out  2  constant 2'b01 (INCR).
- o_arvalid  out  1  AXI address valid.
- i_arready  in  1  AXI address ready.
- i_rdata  in  DATA_WIDTH  AXI read data.
- i_rresp  in  2  AXI read response.
- i_rvalid  in  1  AXI read valid.
- i_rlast  in  1  AXI read last.
- o_rready  out  1  AXI read ready.
- o_proto_err  out  1  sticky flag for burst-length mismatch.

## Operation
- The FSM has three states: IDLE, ADDR and DATA. Reset puts it in IDLE.
- IDLE:
  - If any i_req bit is set, pick a winner according to the arbitration policy (see Configuration).
  - Register the one-hot winner into o_gnt.
  - Register the line-aligned address into o_araddr. Line alignment clears the low $clog2(BURST_LEN*DATA_WIDTH/8) bits of i_addr[winner].
  - Go to ADDR.
- ADDR:
  - o_arvalid=1.
  - o_araddr and o_gnt stay stable until i_arready is seen.
  - On i_arready, go to DATA and clear the beat counter.
- DATA:
  - o_rready=1.
  - o_rdata=i_rdata, o_rlast=i_rlast and o_rerr=(i_rresp!=2'b00), all combinational.
  - o_rvalid[k]=i_rvalid & o_gnt[k]. Bits of non-granted requesters are never set.
  - Each accepted beat increments the beat counter, which is $clog2(BURST_LEN)+1 bits wide.
  - An accepted beat with i_rlast=1 returns the FSM to IDLE and clears o_gnt.
- Burst-length checking:
  - o_proto_err is set if i_rlast arrives with counter != BURST_LEN-1.
  - It is also set if a beat arrives with counter == BURST_LEN-1 and i_rlast=0.
  - Completion is still governed by i_rlast.
  - o_proto_err clears only on reset.
- Requester rules:
  - i_req and i_addr are held stable until o_gnt is seen.
  - A requester deasserts i_req (registered) on its o_rlast beat. Any i_req still high in the following IDLE cycle is a new request.
- Requests that change while another requester is granted have no effect until IDLE.
- The block issues no error retry. A requester that sees o_rerr handles it itself.

## Timing
- Reset values:
  - State IDLE.
  - o_gnt=0, o_arvalid=0, o_rready=0, o_rvalid=0, o_rlast=0, o_rerr=0.
  - o_araddr=0, o_proto_err=0.
  - o_arlen, o_arsize and o_arburst are constants.
- Latency:
  - i_req is seen in IDLE in cycle N.
  - o_gnt and o_arvalid are high in cycle N+1.
  - A handshake at N+1 puts the FSM in DATA at N+2.
  - Beat data is forwarded in the same cycle it arrives (zero added latency).
- Minimum turnaround between bursts is 1 IDLE cycle after the rlast beat.
- Reset asserted mid-burst clears everything immediately, including o_arvalid. The interconnect is reset on the same signal.
- R beats arriving in IDLE or ADDR are not accepted (o_rready=0).

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration.
  - A priority pointer starts at requester 0 after reset.
  - The pointer moves to (winner+1) mod NUM_REQ when a burst completes.
  - The search starts at the pointer.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: the lowest-index active request wins.
  - No pointer is built.

## Test plan
- Single request, requester 1, i_addr=0x0000_1234, i_arready=1:
  - o_araddr=0x0000_1230, o_arlen=3, o_gnt=4'b0010 from cycle N+1.
  - Four beats 0xA0..0xA3 appear only on o_rvalid[1], with o_rlast on the 4th beat.
- Simultaneous i_req=4'b1111, responder returns bursts immediately:
  - With ARB_ROUND_ROBIN_EN, grant order is 0,1,2,3.
  - Without ARB_ROUND_ROBIN_EN, and requesters dropping i_req after completion, grant order is also 0,1,2,3.
  - Without ARB_ROUND_ROBIN_EN and requester 0 re-requesting, requester 0 wins every time.
- i_arready held low for 5 cycles:
  - o_arvalid, o_araddr and o_gnt are stable for all 5 cycles.
  - The burst completes normally afterward.
- Beat 2 with i_rresp=2'b10:
  - o_rerr=1 on that beat only.
  - The burst still completes on i_rlast.
- i_rlast on beat 3 of 4:
  - FSM returns to IDLE and o_proto_err=1.
  - o_proto_err stays 1 through later good bursts until i_areset.
- i_areset pulsed during DATA beat 2:
  - All outputs return to their reset values in the same cycle.
  - The next request is served normally.
